// File: rtl/ift_mem_arbiter.sv
// ift_mem_arbiter
// Two-requester round-robin arbiter in front of a single-port SRAM, with
// information-flow taint (_t0) tracking on every data and control path.
// Requester 0 is the core and requester 1 is the loader.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/addr_i/wdata_i/strb_i/we_i (+_t0)
//                         per-requester request fields and their taint
//   gnt_o (+_t0)          zero-cycle combinational grant, one-hot or zero
//   rvalid_o (+_t0)       read response valid, one cycle after the grant
//   rdata_o (+_t0)        shared read data, passed through from the SRAM
//   mem_* (+_t0)          SRAM request port, carrying the granted requester
//   mem_rdata_i (+_t0)    SRAM read data, valid one cycle after a request
//
// Handshake: a request is accepted in the same cycle that gnt_o[k] is high.
// The requester must hold req_i[k] and its fields until it sees the grant.
// Dropping the request before the grant is the same as never raising it.
// A read that is granted in cycle N gets rvalid_o[k] in cycle N+1, with the
// data on rdata_o. Responses have no backpressure, and writes get no
// response.
module ift_mem_arbiter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StrbWidth = DataWidth >> 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     req_i,
  input  logic [1:0]                     req_i_t0,
  input  logic [1:0][AddrWidth-1:0]      addr_i,
  input  logic [1:0][AddrWidth-1:0]      addr_i_t0,
  input  logic [1:0][DataWidth-1:0]      wdata_i,
  input  logic [1:0][DataWidth-1:0]      wdata_i_t0,
  input  logic [1:0][StrbWidth-1:0]      strb_i,
  input  logic [1:0][StrbWidth-1:0]      strb_i_t0,
  input  logic [1:0]                     we_i,
  input  logic [1:0]                     we_i_t0,
  output logic [1:0]                     gnt_o,
  output logic [1:0]                     gnt_o_t0,
  output logic [1:0]                     rvalid_o,
  output logic [1:0]                     rvalid_o_t0,
  output logic [DataWidth-1:0]           rdata_o,
  output logic [DataWidth-1:0]           rdata_o_t0,
  output logic                           mem_req_o,
  output logic                           mem_req_o_t0,
  output logic                           mem_we_o,
  output logic                           mem_we_o_t0,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [AddrWidth-1:0]           mem_addr_o_t0,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [DataWidth-1:0]           mem_wdata_o_t0,
  output logic [StrbWidth-1:0]           mem_strb_o,
  output logic [StrbWidth-1:0]           mem_strb_o_t0,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  input  logic [DataWidth-1:0]           mem_rdata_i_t0
);

  // Round-robin pointer: the requester that wins the next contention.
  logic r_prio;
  // Registered response state for the access granted in the previous cycle.
  logic r_owner;
  logic r_rd_pend;
  logic r_rv_t0;
  logic r_sel_t0;

  logic [1:0] w_gnt;
  logic [1:0] w_gnt_t0;
  logic       w_any;
  logic       w_idx;
  logic       w_sel_t0;

  always_comb begin
    w_gnt = 2'b00;
    unique case (req_i)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
      default: w_gnt = 2'b00;
    endcase
  end

  assign w_any = |w_gnt;
  assign w_idx = w_gnt[1];

  // The choice of winner itself leaks taint when both requesters compete
  // and either request line is tainted.
  assign w_sel_t0 = (&req_i) & (|req_i_t0);
  assign w_gnt_t0 = req_i_t0 | {2{w_sel_t0}};

  assign gnt_o    = w_gnt;
  assign gnt_o_t0 = w_gnt_t0;

  assign mem_req_o    = w_any;
  assign mem_req_o_t0 = (|(w_gnt & req_i_t0)) | w_sel_t0;

  assign mem_we_o    = w_any ? we_i[w_idx]    : 1'b0;
  assign mem_addr_o  = w_any ? addr_i[w_idx]  : '0;
  assign mem_wdata_o = w_any ? wdata_i[w_idx] : '0;
  assign mem_strb_o  = w_any ? strb_i[w_idx]  : '0;

  // Data taint: the granted requester's own taint. When the winner was
  // chosen by a tainted decision, add every bit where the two candidates
  // differ or where either candidate is already tainted.
  assign mem_we_o_t0 = (w_any ? we_i_t0[w_idx] : 1'b0)
                     | (w_sel_t0 ? ((we_i[0] ^ we_i[1]) | we_i_t0[0] | we_i_t0[1]) : 1'b0);
  assign mem_addr_o_t0 = (w_any ? addr_i_t0[w_idx] : '0)
                       | (w_sel_t0 ? ((addr_i[0] ^ addr_i[1]) | addr_i_t0[0] | addr_i_t0[1]) : '0);
  assign mem_wdata_o_t0 = (w_any ? wdata_i_t0[w_idx] : '0)
                        | (w_sel_t0 ? ((wdata_i[0] ^ wdata_i[1]) | wdata_i_t0[0] | wdata_i_t0[1]) : '0);
  assign mem_strb_o_t0 = (w_any ? strb_i_t0[w_idx] : '0)
                       | (w_sel_t0 ? ((strb_i[0] ^ strb_i[1]) | strb_i_t0[0] | strb_i_t0[1]) : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rv_t0   <= 1'b0;
      r_sel_t0  <= 1'b0;
    end else begin
      if (w_any) r_prio <= ~w_idx;
      r_owner   <= w_idx;
      r_rd_pend <= w_any & ~we_i[w_idx];
      // The response is tainted if the grant or the read/write choice was
      // tainted. It is raised even when the access is a write, because a
      // tainted write-enable may really have been a read.
      r_rv_t0   <= w_any & (w_gnt_t0[w_idx] | we_i_t0[w_idx])
                         & (~we_i[w_idx] | we_i_t0[w_idx]);
      r_sel_t0  <= w_sel_t0;
    end
  end

  assign rvalid_o    = {r_rd_pend & r_owner, r_rd_pend & ~r_owner};
  assign rvalid_o_t0 = r_sel_t0 ? 2'b11 : {r_rv_t0 & r_owner, r_rv_t0 & ~r_owner};

  assign rdata_o    = mem_rdata_i;
  assign rdata_o_t0 = mem_rdata_i_t0;

endmodule

// File: tb/tb_ift_mem_arbiter.sv
module tb_ift_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req, req_t0, we, we_t0;
  logic [1:0][63:0] addr, addr_t0, wdata, wdata_t0;
  logic [1:0][7:0]  strb, strb_t0;
  logic [1:0]       gnt, gnt_t0, rvalid, rvalid_t0;
  logic [63:0]      rdata, rdata_t0, mem_rdata, mem_rdata_t0;
  logic             mem_req, mem_req_t0, mem_we, mem_we_t0;
  logic [63:0]      mem_addr, mem_addr_t0, mem_wdata, mem_wdata_t0;
  logic [7:0]       mem_strb, mem_strb_t0;

  ift_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_i_t0(req_t0),
    .addr_i(addr), .addr_i_t0(addr_t0),
    .wdata_i(wdata), .wdata_i_t0(wdata_t0),
    .strb_i(strb), .strb_i_t0(strb_t0),
    .we_i(we), .we_i_t0(we_t0),
    .gnt_o(gnt), .gnt_o_t0(gnt_t0),
    .rvalid_o(rvalid), .rvalid_o_t0(rvalid_t0),
    .rdata_o(rdata), .rdata_o_t0(rdata_t0),
    .mem_req_o(mem_req), .mem_req_o_t0(mem_req_t0),
    .mem_we_o(mem_we), .mem_we_o_t0(mem_we_t0),
    .mem_addr_o(mem_addr), .mem_addr_o_t0(mem_addr_t0),
    .mem_wdata_o(mem_wdata), .mem_wdata_o_t0(mem_wdata_t0),
    .mem_strb_o(mem_strb), .mem_strb_o_t0(mem_strb_t0),
    .mem_rdata_i(mem_rdata), .mem_rdata_i_t0(mem_rdata_t0)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; checks run 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; req_t0 = '0; we = '0; we_t0 = '0;
    addr = '0; addr_t0 = '0; wdata = '0; wdata_t0 = '0;
    strb = '0; strb_t0 = '0;
    mem_rdata = '0; mem_rdata_t0 = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    clear_inputs();
    @(negedge clk);
    #1;
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_rvalid_t0", 64'(rvalid_t0), 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_addr_idle", mem_addr, 64'h0);

    // The grant path keeps working while reset is held, with the pointer at 0.
    req = 2'b10;
    #1;
    check("rst_gnt_single", 64'(gnt), 64'h2);
    req = 2'b11;
    #1;
    check("rst_gnt_both", 64'(gnt), 64'h1);
    next_cycle();
    #1;
    check("rst_gnt_hold", 64'(gnt), 64'h1);

    // Reset release with both requesting, untainted: the grant alternates.
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    addr[0] = 64'h100; addr[1] = 64'h200;
    prev_gnt = 2'b00;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("rr_gnt_%0d", i), 64'(gnt), 64'(exp_gnt));
      check($sformatf("rr_gnt_t0_%0d", i), 64'(gnt_t0), 64'h0);
      check($sformatf("rr_rvalid_%0d", i), 64'(rvalid), 64'(prev_gnt));
      prev_gnt = exp_gnt;
      next_cycle();
    end

    // Loader-only read of 0x80000008.
    clear_inputs();
    req = 2'b10;
    addr[1] = 64'h8000_0008;
    #1;
    check("ld_gnt", 64'(gnt), 64'h2);
    check("ld_mem_req", 64'(mem_req), 64'h1);
    check("ld_mem_addr", mem_addr, 64'h8000_0008);
    check("ld_mem_we", 64'(mem_we), 64'h0);
    next_cycle();
    req = 2'b00;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    mem_rdata_t0 = 64'h0000_0000_0000_00F0;
    #1;
    check("ld_rvalid", 64'(rvalid), 64'h2);
    check("ld_rdata", rdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("ld_rdata_t0", rdata_t0, 64'h0000_0000_0000_00F0);
    check("idle_mem_addr", mem_addr, 64'h0);
    check("idle_mem_req", 64'(mem_req), 64'h0);

    // Core write with a full strobe: it gets no response. The pointer is now 0.
    clear_inputs();
    req = 2'b01; we[0] = 1'b1; strb[0] = 8'hFF;
    addr[0] = 64'h40; wdata[0] = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("wr_gnt", 64'(gnt), 64'h1);
    check("wr_mem_we", 64'(mem_we), 64'h1);
    check("wr_mem_strb", 64'(mem_strb), 64'hFF);
    check("wr_mem_wdata", mem_wdata, 64'h1234_5678_9ABC_DEF0);
    next_cycle();
    clear_inputs();
    #1;
    check("wr_rvalid", 64'(rvalid), 64'h0);

    // Contention with a tainted loader request. The pointer is 1, so the loader wins.
    req = 2'b11; req_t0 = 2'b10;
    addr[0] = 64'h1000; addr[1] = 64'h1010;
    #1;
    check("tc_gnt", 64'(gnt), 64'h2);
    check("tc_gnt_t0", 64'(gnt_t0), 64'h3);
    check("tc_mem_req_t0", 64'(mem_req_t0), 64'h1);
    check("tc_mem_addr_t0", mem_addr_t0, 64'h10);
    check("tc_mem_we_t0", 64'(mem_we_t0), 64'h0);
    next_cycle();
    clear_inputs();
    #1;
    check("tc_rvalid", 64'(rvalid), 64'h2);
    check("tc_rvalid_t0", 64'(rvalid_t0), 64'h3);

    // A single tainted request has no decision taint. The pointer is 0.
    req = 2'b01; req_t0 = 2'b01;
    #1;
    check("st_gnt_t0", 64'(gnt_t0), 64'h1);
    check("st_mem_req_t0", 64'(mem_req_t0), 64'h1);
    next_cycle();
    clear_inputs();
    #1;
    check("st_rvalid_t0", 64'(rvalid_t0), 64'h1);

    // Core read granted (the pointer then moves to 1). Reset pulses before the response.
    req = 2'b01;
    #1;
    check("rr_pre_gnt", 64'(gnt), 64'h1);
    @(posedge clk);
    #2;
    req = 2'b00;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_rvalid", 64'(rvalid), 64'h0);
    req = 2'b11;
    #1;
    check("rstmid_prio", 64'(gnt), 64'h1);
    next_cycle();
    clear_inputs();
    #1;
    check("post_rvalid", 64'(rvalid), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
